// File: rtl/rptr_aempty_tmr.sv
// Read-side pointer / empty / almost-empty / fill-level controller for gray async FIFOs, optional TMR state.
// Latency: raddr combinational from registered rbin; rptr, rempty, raempty, rcount, seu_err registered (1 rclk).
// Backpressure: rinc is honoured only while rempty=0; reads against an empty FIFO are silently dropped.
//
// Ports:
//   rclk, rrst_n      read clock, asynchronous active-low reset
//   rinc              read request
//   rq2_wptr          gray write pointer already synchronised into rclk
//   aempty_thr        almost-empty threshold in words (binary)
//   seu_cnt_clr       synchronous clear of seu_cnt
//   raddr             memory read address (low bits of binary read pointer)
//   rptr              gray read pointer towards the write-domain synchroniser
//   rempty, raempty   empty / fill level <= aempty_thr
//   rcount            words held as seen from the read side
//   seu_err, seu_cnt  one-cycle copy-disagreement pulse and its saturating count
module rptr_aempty_tmr #(
    parameter int ADDRSIZE  = 3,
    parameter int TMR       = 1,
    parameter int SEU_CNT_W = 8
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rinc,
    input  logic [ADDRSIZE:0]    rq2_wptr,
    input  logic [ADDRSIZE:0]    aempty_thr,
    input  logic                 seu_cnt_clr,
    output logic [ADDRSIZE-1:0]  raddr,
    output logic [ADDRSIZE:0]    rptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDRSIZE:0]    rcount,
    output logic                 seu_err,
    output logic [SEU_CNT_W-1:0] seu_cnt
);

    localparam logic [SEU_CNT_W-1:0] CNT_ONE = {{(SEU_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SEU_CNT_W-1:0] CNT_MAX = {SEU_CNT_W{1'b1}};

    // State copies. Copy 0 always exists; copies 1/2 are real only when TMR=1.
    logic [ADDRSIZE:0] rbin_c0,    rbin_c1,    rbin_c2,    rbin_v;
    logic [ADDRSIZE:0] rptr_c0,    rptr_c1,    rptr_c2,    rptr_v;
    logic              rempty_c0,  rempty_c1,  rempty_c2,  rempty_v;
    logic              raempty_c0, raempty_c1, raempty_c2, raempty_v;
    logic [ADDRSIZE:0] rcount_c0,  rcount_c1,  rcount_c2,  rcount_v;

    // Next-state values shared by every copy (this is also the scrub value).
    logic              rd_ok;
    logic [ADDRSIZE:0] rbin_nxt;
    logic [ADDRSIZE:0] rgray_nxt;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rcount_nxt;
    logic              rempty_nxt;
    logic              raempty_nxt;

    // Per-bit majority vote; with a single copy this degenerates to copy 0.
    assign rbin_v    = (rbin_c0 & rbin_c1)       | (rbin_c1 & rbin_c2)       | (rbin_c0 & rbin_c2);
    assign rptr_v    = (rptr_c0 & rptr_c1)       | (rptr_c1 & rptr_c2)       | (rptr_c0 & rptr_c2);
    assign rempty_v  = (rempty_c0 & rempty_c1)   | (rempty_c1 & rempty_c2)   | (rempty_c0 & rempty_c2);
    assign raempty_v = (raempty_c0 & raempty_c1) | (raempty_c1 & raempty_c2) | (raempty_c0 & raempty_c2);
    assign rcount_v  = (rcount_c0 & rcount_c1)   | (rcount_c1 & rcount_c2)   | (rcount_c0 & rcount_c2);

    assign rd_ok     = rinc & ~rempty_v;
    assign rbin_nxt  = rbin_v + {{ADDRSIZE{1'b0}}, rd_ok};
    assign rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt;

    // Gray to binary: each binary bit is the parity of the gray bits at and above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Fill level uses the post-read pointer so a read and a write in the same
    // cycle both show up at the same edge.
    assign rcount_nxt  = wbin - rbin_nxt;
    assign rempty_nxt  = (rgray_nxt == rq2_wptr);
    assign raempty_nxt = (rcount_nxt <= aempty_thr);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_c0    <= '0;
            rptr_c0    <= '0;
            rempty_c0  <= 1'b1;
            raempty_c0 <= 1'b1;
            rcount_c0  <= '0;
        end else begin
            rbin_c0    <= rbin_nxt;
            rptr_c0    <= rgray_nxt;
            rempty_c0  <= rempty_nxt;
            raempty_c0 <= raempty_nxt;
            rcount_c0  <= rcount_nxt;
        end
    end

    generate
        if (TMR != 0) begin : g_tmr
            logic disagree;

            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    rbin_c1    <= '0;
                    rptr_c1    <= '0;
                    rempty_c1  <= 1'b1;
                    raempty_c1 <= 1'b1;
                    rcount_c1  <= '0;
                    rbin_c2    <= '0;
                    rptr_c2    <= '0;
                    rempty_c2  <= 1'b1;
                    raempty_c2 <= 1'b1;
                    rcount_c2  <= '0;
                end else begin
                    rbin_c1    <= rbin_nxt;
                    rptr_c1    <= rgray_nxt;
                    rempty_c1  <= rempty_nxt;
                    raempty_c1 <= raempty_nxt;
                    rcount_c1  <= rcount_nxt;
                    rbin_c2    <= rbin_nxt;
                    rptr_c2    <= rgray_nxt;
                    rempty_c2  <= rempty_nxt;
                    raempty_c2 <= raempty_nxt;
                    rcount_c2  <= rcount_nxt;
                end
            end

            // Any copy that disagrees with a neighbour is an upset; the
            // pairs (0,1) and (1,2) together cover every single-copy fault.
            assign disagree = (|(rbin_c0 ^ rbin_c1))       | (|(rbin_c1 ^ rbin_c2))
                            | (|(rptr_c0 ^ rptr_c1))       | (|(rptr_c1 ^ rptr_c2))
                            | (rempty_c0 ^ rempty_c1)      | (rempty_c1 ^ rempty_c2)
                            | (raempty_c0 ^ raempty_c1)    | (raempty_c1 ^ raempty_c2)
                            | (|(rcount_c0 ^ rcount_c1))   | (|(rcount_c1 ^ rcount_c2));

            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    seu_err <= 1'b0;
                    seu_cnt <= '0;
                end else begin
                    seu_err <= disagree;
                    // Clear takes priority over a coincident increment.
                    if (seu_cnt_clr) begin
                        seu_cnt <= '0;
                    end else if (seu_err && (seu_cnt != CNT_MAX)) begin
                        seu_cnt <= seu_cnt + CNT_ONE;
                    end
                end
            end
        end else begin : g_single
            assign rbin_c1    = rbin_c0;
            assign rptr_c1    = rptr_c0;
            assign rempty_c1  = rempty_c0;
            assign raempty_c1 = raempty_c0;
            assign rcount_c1  = rcount_c0;
            assign rbin_c2    = rbin_c0;
            assign rptr_c2    = rptr_c0;
            assign rempty_c2  = rempty_c0;
            assign raempty_c2 = raempty_c0;
            assign rcount_c2  = rcount_c0;
            assign seu_err    = 1'b0;
            assign seu_cnt    = '0;
        end
    endgenerate

    assign raddr   = rbin_v[ADDRSIZE-1:0];
    assign rptr    = rptr_v;
    assign rempty  = rempty_v;
    assign raempty = raempty_v;
    assign rcount  = rcount_v;

endmodule

// File: tb/tb_rptr_aempty_tmr.sv
// Randomised and directed bench for rptr_aempty_tmr (ADDRSIZE=3, TMR=1, SEU_CNT_W=8).
// Reference model tracks total words written/read as integers and derives all outputs from them.
// Upsets are injected by forcing copy 0 of the binary read pointer for part of one cycle.
module tb_rptr_aempty_tmr;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [3:0] aempty_thr;
    logic       seu_cnt_clr;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [3:0] rcount;
    logic       seu_err;
    logic [7:0] seu_cnt;

    rptr_aempty_tmr #(
        .ADDRSIZE (3),
        .TMR      (1),
        .SEU_CNT_W(8)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .aempty_thr (aempty_thr),
        .seu_cnt_clr(seu_cnt_clr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .seu_err    (seu_err),
        .seu_cnt    (seu_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: totals of words ever written / read since reset.
    int wr_total;
    int rd_total;
    int m_thr;
    int m_count;
    bit m_empty;
    bit m_aempty;
    bit m_err;
    int m_cnt;
    logic [3:0] inj_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [2:0] addr3(input int b);
        logic [2:0] x;
        x = b[2:0];
        return x;
    endfunction

    task automatic model_reset();
        wr_total = 0;
        rd_total = 0;
        m_count  = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":rempty"},  rempty,  m_empty);
        chk({tag, ":raempty"}, raempty, m_aempty);
        chk({tag, ":rcount"},  rcount,  m_count);
        chk({tag, ":rptr"},    rptr,    gray4(rd_total));
        chk({tag, ":raddr"},   raddr,   addr3(rd_total));
        chk({tag, ":seu_err"}, seu_err, m_err);
        chk({tag, ":seu_cnt"}, seu_cnt, m_cnt);
    endtask

    // One rclk cycle. Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit w, input bit r, input bit inj, input bit clr);
        if (w && (wr_total - rd_total) < 8) wr_total++;
        rq2_wptr    = gray4(wr_total);
        rinc        = r;
        seu_cnt_clr = clr;
        aempty_thr  = m_thr[3:0];
        // Effect of the coming edge, from the pre-edge (registered) empty flag.
        if (r && !m_empty) rd_total++;
        m_count  = wr_total - rd_total;
        m_empty  = (m_count == 0);
        m_aempty = (m_count <= m_thr);
        if (clr) m_cnt = 0;
        else if (m_err && m_cnt < 255) m_cnt++;
        m_err = inj;
        if (inj) begin
            inj_val = dut.rbin_c0 ^ 4'b0010;
            force dut.rbin_c0 = inj_val;
            #7;
            release dut.rbin_c0;
        end
        @(posedge rclk);
        #1;
        check_all("step");
        if (inj) chk("scrub_c0", dut.rbin_c0, rd_total[3:0]);
    endtask

    initial begin
        rrst_n      = 1'b0;
        rinc        = 1'b0;
        rq2_wptr    = '0;
        aempty_thr  = 4'd1;
        seu_cnt_clr = 1'b0;
        m_thr       = 1;
        model_reset();
        #23;
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;

        // Reset and idle.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("rst:rempty", rempty, 1'b1);
        chk("rst:raempty", raempty, 1'b1);
        chk("rst:rptr", rptr, 4'b0000);
        chk("rst:rcount", rcount, 4'd0);

        // Three writes with threshold 1, then three reads.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("fill3:rcount", rcount, 4'd3);
        chk("fill3:raempty", raempty, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("drain:raddr", raddr, i);
            step(0, 1, 0, 0);
        end
        chk("drain:rptr", rptr, 4'b0010);
        chk("drain:rempty", rempty, 1'b1);
        chk("drain:raempty", raempty, 1'b1);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            if (m_count > 0) chk("stream:no_spurious_empty", rempty, 1'b0);
        end

        // Drain, then hammer rinc on an empty FIFO.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("underflow:empty_before", rempty, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        chk("underflow:rptr", rptr, gray4(rd_total));

        // Single upset mid-stream, then saturation, then clear vs increment.
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("seu1:err", seu_err, 1'b1);
        step(1, 1, 0, 0);
        chk("seu1:cnt", seu_cnt, 8'd1);
        chk("seu1:err_gone", seu_err, 1'b0);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
        step(0, 0, 0, 0);
        chk("seu_sat:cnt", seu_cnt, 8'd255);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("seu_clr:cnt", seu_cnt, 8'd0);

        // Randomised mix with threshold changes (including >= depth) and injections.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) m_thr = $urandom_range(0, 9);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
            if (m_thr == 0) chk("thr0:raempty_eq_rempty", raempty, rempty);
            if (m_thr >= 8) chk("thr_big:raempty", raempty, 1'b1);
        end

        // Asynchronous reset with five words held.
        m_thr = 2;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("pre_arst:rcount", rcount, 4'd5);
        rrst_n = 1'b0;
        #2;
        model_reset();
        chk("arst:rempty", rempty, 1'b1);
        chk("arst:raempty", raempty, 1'b1);
        chk("arst:rcount", rcount, 4'd0);
        chk("arst:rptr", rptr, 4'd0);
        chk("arst:raddr", raddr, 3'd0);
        chk("arst:seu_err", seu_err, 1'b0);
        chk("arst:seu_cnt", seu_cnt, 8'd0);
        rq2_wptr = '0;
        rinc     = 1'b0;
        @(posedge rclk);
        #3;
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("resume:raddr0", raddr, 3'd0);
        step(0, 1, 0, 0);
        chk("resume:raddr1", raddr, 3'd1);
        step(0, 1, 0, 0);
        chk("resume:empty", rempty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
